// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the timer controller and the digit chain it drives.
// State encodings and digit selects are fixed because the digit modules decode them.
package timer_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_SET   = 2'd3
    } state_t;

    localparam logic [1:0] SEL_SEC_L = 2'd0;
    localparam logic [1:0] SEL_SEC_H = 2'd1;
    localparam logic [1:0] SEL_MIN_L = 2'd2;
    localparam logic [1:0] SEL_MIN_H = 2'd3;

    // Counter width that stays legal when the modulus is 1.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/timer_ctrl_if.sv
// Button pulses in, digit-chain controls out, between the controller and its neighbours.
// master = timer_ctrl side, slave = button source / digit chain side.
interface timer_ctrl_if;
    logic       btn_start_stop;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_clr;
    logic       dsyn_rst_n;
    logic       sec_tick;
    logic       set_inc;
    logic [1:0] set_sel;
    logic       clr_pulse;
    logic       running;
    logic       blink;

    modport master (
        input  btn_start_stop, btn_mode, btn_inc, btn_clr,
        output dsyn_rst_n, sec_tick, set_inc, set_sel, clr_pulse, running, blink
    );

    modport slave (
        output btn_start_stop, btn_mode, btn_inc, btn_clr,
        input  dsyn_rst_n, sec_tick, set_inc, set_sel, clr_pulse, running, blink
    );
endinterface

// File: rtl/timer_prescaler.sv
// Seconds prescaler: counts while en, emits a registered one-cycle tick on wrap.
// Latency: tick appears the cycle after the count sits at DIV-1 with en high.
// No backpressure; clr synchronously zeroes count and tick, en low holds the count.
module timer_prescaler #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    import timer_ctrl_pkg::*;

    localparam int CNT_W = clog2_min1(DIV);

    if (DIV < 2) begin : g_bad_div
        $error("timer_prescaler: DIV must be at least 2");
    end

    logic [CNT_W-1:0] cnt_q;
    logic             wrap;

    assign wrap = (cnt_q == CNT_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else if (en) begin
            cnt_q <= wrap ? '0 : cnt_q + 1'b1;
            tick  <= wrap;
        end else begin
            tick  <= 1'b0;
        end
    end
endmodule

// File: rtl/timer_ctrl.sv
// Run/pause/set controller for the timer digit chain; optional set-mode blink via TIMER_CTRL_BLINK_EN.
// Latency: one cycle from a button pulse to the registered state/pulse outputs.
// No backpressure: button pulses are single-cycle; lower-priority pulses in the same cycle are dropped.
module timer_ctrl #(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int TICK_HZ     = 1,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic          clk,
    input  logic          rst_n,
    timer_ctrl_if.master  bus
);
    import timer_ctrl_pkg::*;

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;

    if (BLINK_DIV < 1) begin : g_bad_blink
        $error("timer_ctrl: BLINK_DIV must be at least 1");
    end

    state_t     state_q, state_d;
    logic [1:0] set_sel_q, set_sel_d;
    logic       set_inc_q, set_inc_d;
    logic       clr_q, clr_d;
    logic       running_q;
    logic       mode_step;
    logic       pre_en;
    logic       sec_tick_w;
    logic       sync1_q, sync2_q;

    // Priority chain: clr > start_stop > mode > inc.
    always_comb begin
        state_d   = state_q;
        set_sel_d = set_sel_q;
        set_inc_d = 1'b0;
        clr_d     = 1'b0;
        mode_step = 1'b0;
        if (bus.btn_clr) begin
            state_d   = ST_IDLE;
            set_sel_d = SEL_SEC_L;
            clr_d     = 1'b1;
        end else if (bus.btn_start_stop) begin
            set_sel_d = SEL_SEC_L;
            state_d   = (state_q == ST_RUN) ? ST_PAUSE : ST_RUN;
            if (state_q == ST_RUN) set_sel_d = set_sel_q;
        end else if (bus.btn_mode) begin
            case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    state_d   = ST_SET;
                    set_sel_d = SEL_SEC_L;
                end
                ST_SET: begin
                    mode_step = 1'b1;
                    if (set_sel_q == SEL_MIN_H) begin
                        state_d   = ST_PAUSE;
                        set_sel_d = SEL_SEC_L;
                    end else begin
                        set_sel_d = set_sel_q + 2'd1;
                    end
                end
                default: ;
            endcase
        end else if (bus.btn_inc) begin
            set_inc_d = (state_q == ST_SET);
        end
    end

    // Counting only when RUN persists makes a pause on the wrap cycle hold at DIV-1.
    assign pre_en = (state_q == ST_RUN) && (state_d == ST_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            set_sel_q <= SEL_SEC_L;
            set_inc_q <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            set_sel_q <= set_sel_d;
            set_inc_q <= set_inc_d;
            clr_q     <= clr_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    timer_prescaler #(.DIV(DIV)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pre_en),
        .clr   (clr_d),
        .tick  (sec_tick_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= 1'b1;
            sync2_q <= sync1_q;
        end
    end

`ifdef TIMER_CTRL_BLINK_EN
    localparam int BLK_W = clog2_min1(BLINK_DIV);

    logic [BLK_W-1:0] blink_cnt_q;
    logic             blink_q;
    logic             blink_restart;

    assign blink_restart = (state_q != ST_SET) || mode_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (state_d != ST_SET || blink_restart) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b1;
        end else if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blink_cnt_q <= '0;
            blink_q     <= ~blink_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end

    assign bus.blink = blink_q;
`else
    logic unused_mode_step;
    assign unused_mode_step = mode_step;
    assign bus.blink        = 1'b1;
`endif

    assign bus.dsyn_rst_n = sync2_q;
    assign bus.sec_tick   = sec_tick_w;
    assign bus.set_inc    = set_inc_q;
    assign bus.set_sel    = set_sel_q;
    assign bus.clr_pulse  = clr_q;
    assign bus.running    = running_q;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with DIV=10 and BLINK_DIV=4; vector table plus multi-cycle sequences.
module tb_timer_ctrl;

`ifdef TIMER_CTRL_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    timer_ctrl_if bus ();

    timer_ctrl #(
        .CLK_FREQ_HZ (10),
        .TICK_HZ     (1),
        .BLINK_DIV   (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // btn = {clr, start_stop, mode, inc}
    typedef struct {
        logic [3:0] btn;
        logic       run;
        logic [1:0] sel;
        logic       inc;
        logic       clr;
        logic       tick;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] btn);
        {bus.btn_clr, bus.btn_start_stop, bus.btn_mode, bus.btn_inc} = btn;
        @(posedge clk);
        #1;
        {bus.btn_clr, bus.btn_start_stop, bus.btn_mode, bus.btn_inc} = 4'b0000;
    endtask

    initial begin
        int ticks;
        int tick_at [3];
        int k;

        vecs[0]  = '{4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'b0001, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'b0010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'b0010, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'b0010, 1'b0, 2'd3, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'b0010, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{4'b0001, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'b0100, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'b0010, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'b0001, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'b0111, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'b0011, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{4'b0010, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{4'b0110, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{4'b1100, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{4'b0000, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{4'b1000, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[20] = '{4'b0100, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0};

        {bus.btn_clr, bus.btn_start_stop, bus.btn_mode, bus.btn_inc} = 4'b0000;

        // Reset values, before and after edges under reset
        #3;
        check("rst_dsyn", bus.dsyn_rst_n, 0);
        check("rst_running", bus.running, 0);
        check("rst_sel", bus.set_sel, 0);
        check("rst_blink", bus.blink, 1);
        @(posedge clk); @(posedge clk); #1;
        check("rst_hold_dsyn", bus.dsyn_rst_n, 0);
        check("rst_tick", bus.sec_tick, 0);
        check("rst_inc", bus.set_inc, 0);
        check("rst_clr", bus.clr_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("dsyn_edge1", bus.dsyn_rst_n, 0);
        @(posedge clk); #1;
        check("dsyn_edge2", bus.dsyn_rst_n, 1);

        // FSM vector table
        for (int i = 0; i < 21; i++) begin
            step(vecs[i].btn);
            check($sformatf("v%0d_running", i), bus.running, vecs[i].run);
            check($sformatf("v%0d_sel", i), bus.set_sel, vecs[i].sel);
            check($sformatf("v%0d_set_inc", i), bus.set_inc, vecs[i].inc);
            check($sformatf("v%0d_clr_pulse", i), bus.clr_pulse, vecs[i].clr);
            check($sformatf("v%0d_sec_tick", i), bus.sec_tick, vecs[i].tick);
            check($sformatf("v%0d_blink", i), bus.blink, 1);
        end

        // Free run: three ticks, 10 cycles apart
        step(4'b1000);
        step(4'b0100);
        check("run_start", bus.running, 1);
        ticks = 0;
        for (int i = 1; i <= 35; i++) begin
            step(4'b0000);
            if (bus.sec_tick) begin
                if (ticks < 3) tick_at[ticks] = i;
                ticks++;
            end
        end
        check("run_tick_count", ticks, 3);
        if (ticks >= 3) begin
            check("run_tick0", tick_at[0], 10);
            check("run_tick1", tick_at[1], 20);
            check("run_tick2", tick_at[2], 30);
        end

        // Pause keeps the partial second
        step(4'b1000);
        step(4'b0100);
        for (int i = 0; i < 4; i++) step(4'b0000);
        step(4'b0100);
        check("pause_running", bus.running, 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0000);
            if (bus.sec_tick) ticks++;
        end
        check("pause_no_ticks", ticks, 0);
        step(4'b0100);
        k = -1;
        for (int i = 1; i <= 30; i++) begin
            step(4'b0000);
            if (bus.sec_tick && k < 0) k = i;
        end
        check("resume_first_tick", k, 6);

        // Pause on the wrap cycle: tick deferred to first RUN cycle after resume
        step(4'b1000);
        step(4'b0100);
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            step(4'b0000);
            if (bus.sec_tick) ticks++;
        end
        check("wrap_pre_ticks", ticks, 0);
        step(4'b0100);
        check("wrap_pause_tick", bus.sec_tick, 0);
        check("wrap_pause_running", bus.running, 0);
        step(4'b0100);
        check("wrap_resume_tick", bus.sec_tick, 0);
        check("wrap_resume_running", bus.running, 1);
        step(4'b0000);
        check("wrap_deferred_tick", bus.sec_tick, 1);
        step(4'b0000);
        check("wrap_tick_width", bus.sec_tick, 0);

        // clr + start_stop in RUN: clear wins, prescaler restarts from 0
        for (int i = 0; i < 5; i++) step(4'b0000);
        step(4'b1100);
        check("clrss_clr_pulse", bus.clr_pulse, 1);
        check("clrss_running", bus.running, 0);
        check("clrss_tick", bus.sec_tick, 0);
        step(4'b0000);
        check("clrss_clr_width", bus.clr_pulse, 0);
        step(4'b0100);
        k = -1;
        for (int i = 1; i <= 30; i++) begin
            step(4'b0000);
            if (bus.sec_tick && k < 0) k = i;
        end
        check("clrss_first_tick", k, 10);

        // Blink in SET
        step(4'b1000);
        step(4'b0010);
        check("blink_entry", bus.blink, 1);
        for (int i = 1; i <= 12; i++) begin
            step(4'b0000);
            check($sformatf("blink_c%0d", i), bus.blink,
                  (BLINK_ON && ((i / 4) % 2 == 1)) ? 0 : 1);
        end
        step(4'b0010);
        check("blink_mode_sel", bus.set_sel, 1);
        check("blink_mode_reset", bus.blink, 1);
        for (int i = 1; i <= 4; i++) begin
            step(4'b0000);
            check($sformatf("blink_m%0d", i), bus.blink, (BLINK_ON && i == 4) ? 0 : 1);
        end
        step(4'b0100);
        check("blink_run", bus.blink, 1);
        check("blink_run_running", bus.running, 1);

        // Asynchronous assertion of the display reset
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_dsyn", bus.dsyn_rst_n, 0);
        check("async_running", bus.running, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end expected end");
        $fatal(1);
    end
endmodule
